// File: rtl/mips_muldiv_pkg.sv
// rtl/mips_muldiv_pkg.sv - op encodings and FSM state encoding for the HI/LO multiply/divide unit
package mips_muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DIV  = 2'b10,
      FIX  = 2'b11
   } state_t;

endpackage

// File: rtl/mips_muldiv_div.sv
// rtl/mips_muldiv_div.sv - radix-2 restoring divider datapath on unsigned magnitudes
module mips_muldiv_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] remReg;
   logic [WIDTH-1:0] quoReg;
   logic [WIDTH-1:0] dvsReg;
   logic [WIDTH:0]   shifted;
   logic             fits;
   logic [WIDTH-1:0] trial;

   // Trial subtraction: shift the next dividend bit into the partial remainder and compare.
   // When it fits the difference is below the divisor, so the low WIDTH bits are exact.
   always_comb begin
      shifted = {remReg, quoReg[WIDTH-1]};
      fits    = (shifted >= {1'b0, dvsReg});
      trial   = shifted[WIDTH-1:0] - dvsReg;
   end

   // Quotient bits shift in from the right as dividend bits shift out of the left.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         remReg <= '0;
         quoReg <= '0;
         dvsReg <= '0;
      end else if (load) begin
         remReg <= '0;
         quoReg <= dividend;
         dvsReg <= divisor;
      end else if (step) begin
         remReg <= fits ? trial : shifted[WIDTH-1:0];
         quoReg <= {quoReg[WIDTH-2:0], fits};
      end
   end

   assign quotient  = quoReg;
   assign remainder = remReg;

endmodule

// File: rtl/mips_muldiv.sv
// rtl/mips_muldiv.sv - MIPS HI/LO multiply/divide unit; divider built only with MIPS_MULDIV_DIV_EN
module mips_muldiv
   import mips_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t             state, stateNext;
   logic               sgnReg;
   logic               aNeg, bNeg;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prodAcc;
   logic [CW-1:0]      iterCnt;
   logic               doneReg;
   logic [WIDTH-1:0]   hiReg, loReg;

   logic [WIDTH-1:0]   aMag, bMag;
   logic               accept, mulStep, divStep, resWrite, skipDone;
   logic               lastIter, resNeg;
   logic [WIDTH:0]     mulSum;
   logic [2*WIDTH-1:0] mulNext, prodFinal;
   logic [WIDTH-1:0]   resHi, resLo;

`ifdef MIPS_MULDIV_DIV_EN
   logic               divReg;
   logic               bZero;
   logic [WIDTH-1:0]   aReg;
   logic [WIDTH-1:0]   quo, rem;

   mips_muldiv_div #(.WIDTH(WIDTH)) uDiv (
      .clk       (clk),
      .rst       (rst),
      .load      (accept & op[1]),
      .step      (divStep),
      .dividend  (aMag),
      .divisor   (bMag),
      .quotient  (quo),
      .remainder (rem)
   );
`endif

   // Operand magnitudes for signed ops, raw values for unsigned ops; multiplier step and sign fix.
   always_comb begin
      aMag      = (!op[0] && a[WIDTH-1]) ? -a : a;
      bMag      = (!op[0] && b[WIDTH-1]) ? -b : b;
      lastIter  = (iterCnt == CW'(WIDTH - 1));
      resNeg    = sgnReg & (aNeg ^ bNeg);
      mulSum    = {1'b0, prodAcc[2*WIDTH-1:WIDTH]} + (prodAcc[0] ? {1'b0, mcand} : '0);
      mulNext   = {mulSum, prodAcc[WIDTH-1:1]};
      prodFinal = resNeg ? -prodAcc : prodAcc;
   end

   // Result selection for the FIX write: quotient/remainder take the dividend/sign rules.
   always_comb begin
      resHi = prodFinal[2*WIDTH-1:WIDTH];
      resLo = prodFinal[WIDTH-1:0];
`ifdef MIPS_MULDIV_DIV_EN
      if (divReg) begin
         resLo = resNeg ? -quo : quo;
         resHi = (sgnReg && aNeg) ? -rem : rem;
      end
`endif
   end

   // Next-state and control strobes; cancel always wins over stepping and completion.
   always_comb begin
      stateNext = state;
      accept    = 1'b0;
      mulStep   = 1'b0;
      divStep   = 1'b0;
      resWrite  = 1'b0;
      skipDone  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !cancel) begin
               accept    = 1'b1;
               stateNext = op[1] ? DIV : MUL;
            end
         end
         MUL: begin
            if (cancel) begin
               stateNext = IDLE;
            end else begin
               mulStep = 1'b1;
               if (lastIter) stateNext = FIX;
            end
         end
         DIV: begin
`ifdef MIPS_MULDIV_DIV_EN
            if (cancel) begin
               stateNext = IDLE;
            end else if (bZero) begin
               skipDone  = 1'b1;
               stateNext = IDLE;
            end else begin
               divStep = 1'b1;
               if (lastIter) stateNext = FIX;
            end
`else
            stateNext = IDLE;
            skipDone  = !cancel;
`endif
         end
         FIX: begin
            stateNext = IDLE;
            resWrite  = !cancel;
         end
         default: stateNext = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= stateNext;
   end

   // Operand latches, shift-add multiplier, iteration counter, HI/LO and done flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sgnReg  <= 1'b0;
         aNeg    <= 1'b0;
         bNeg    <= 1'b0;
         mcand   <= '0;
         prodAcc <= '0;
         iterCnt <= '0;
         doneReg <= 1'b0;
         hiReg   <= '0;
         loReg   <= '0;
`ifdef MIPS_MULDIV_DIV_EN
         divReg  <= 1'b0;
         bZero   <= 1'b0;
         aReg    <= '0;
`endif
      end else begin
         doneReg <= 1'b0;
         if (state == IDLE) begin
            if (hi_we) hiReg <= wdata;
            if (lo_we) loReg <= wdata;
         end
         if (accept) begin
            sgnReg  <= ~op[0];
            aNeg    <= a[WIDTH-1];
            bNeg    <= b[WIDTH-1];
            mcand   <= aMag;
            prodAcc <= {{WIDTH{1'b0}}, bMag};
            iterCnt <= '0;
`ifdef MIPS_MULDIV_DIV_EN
            divReg  <= op[1];
            bZero   <= (b == '0);
            aReg    <= a;
`endif
         end
         if (mulStep || divStep) iterCnt <= iterCnt + CW'(1);
         if (mulStep) prodAcc <= mulNext;
         if (resWrite) begin
            hiReg   <= resHi;
            loReg   <= resLo;
            doneReg <= 1'b1;
         end
         if (skipDone) begin
            doneReg <= 1'b1;
`ifdef MIPS_MULDIV_DIV_EN
            hiReg   <= aReg;
            loReg   <= '1;
`endif
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = doneReg;
   assign hi   = hiReg;
   assign lo   = loReg;

endmodule

// File: tb/tb_mips_muldiv.sv
// tb/tb_mips_muldiv.sv - directed-vector bench for mips_muldiv (WIDTH=32, both MIPS_MULDIV_DIV_EN builds)
module tb_mips_muldiv;
   import mips_muldiv_pkg::*;

`ifdef MIPS_MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clk, rst, start, cancel, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic        busy, done;
   logic [31:0] hi, lo;

   int          nVec = 0;
   int          nBad = 0;
   logic [31:0] mHi = '0;
   logic [31:0] mLo = '0;

   mips_muldiv #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .cancel (cancel),
      .hi_we  (hi_we),
      .lo_we  (lo_we),
      .wdata  (wdata),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nVec++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Called just after a falling edge; returns just after a falling edge.
   task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit withMt, input int injectAt,
                        input int cancelAt, input int expBusy, input bit expDone,
                        input logic [31:0] expHi, input logic [31:0] expLo);
      int n;
      int earlyDone;
      start = 1'b1; op = o; a = x; b = y;
      if (withMt) begin lo_we = 1'b1; wdata = 32'h1234; end
      @(negedge clk);
      start = 1'b0; lo_we = 1'b0;
      if (withMt) check({tag, ".mtlo_e0"}, 64'(lo), 64'h1234);
      n = 0;
      earlyDone = 0;
      while (busy && n < 200) begin
         n++;
         if (done) earlyDone++;
         if (n == injectAt) begin
            start = 1'b1; op = OP_DIVU; a = 32'h1; b = 32'h0;
            hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
         end
         if (n == cancelAt) cancel = 1'b1;
         @(negedge clk);
         start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; cancel = 1'b0;
      end
      check({tag, ".busy_cycles"}, 64'(n), 64'(expBusy));
      check({tag, ".done_early"}, 64'(earlyDone), 64'd0);
      check({tag, ".done"}, 64'(done), 64'(expDone));
      check({tag, ".hi"}, 64'(hi), 64'(expHi));
      check({tag, ".lo"}, 64'(lo), 64'(expLo));
      @(negedge clk);
      check({tag, ".done_clr"}, 64'(done), 64'd0);
      check({tag, ".idle"}, 64'(busy), 64'd0);
      if (expDone) begin mHi = expHi; mLo = expLo; end
   endtask

   // Divide helper: expectations switch between the divider build and the stubbed build.
   task automatic divOp(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] q, input logic [31:0] r);
      int eb;
      eb = (y == 32'h0) ? 1 : 33;
      runOp(tag, o, x, y, 1'b0, -1, -1, DIV_EN ? eb : 1, 1'b1,
            DIV_EN ? r : mHi, DIV_EN ? q : mLo);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = OP_MULT; a = '0; b = '0; wdata = '0;
      #1;
      check("reset.busy", 64'(busy), 64'd0);
      check("reset.done", 64'(done), 64'd0);
      check("reset.hi", 64'(hi), 64'd0);
      check("reset.lo", 64'(lo), 64'd0);

      @(negedge clk);
      rst = 1'b1;
      runOp("mult_m3x7", OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, -1, -1, 33, 1'b1,
            32'hFFFFFFFF, 32'hFFFFFFEB);
      runOp("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, -1, 33, 1'b1,
            32'hFFFFFFFE, 32'h00000001);
      runOp("mult_negneg", OP_MULT, 32'hFFFFFFFB, 32'hFFFFFFFA, 1'b0, -1, -1, 33, 1'b1,
            32'h0, 32'h1E);
      runOp("mult_minmin", OP_MULT, 32'h80000000, 32'h80000000, 1'b0, -1, -1, 33, 1'b1,
            32'h40000000, 32'h0);
      runOp("multu_mtlo", OP_MULTU, 32'h12345678, 32'h10, 1'b1, -1, -1, 33, 1'b1,
            32'h1, 32'h23456780);
      runOp("mult_inject", OP_MULT, 32'd3, 32'd4, 1'b0, 5, -1, 33, 1'b1, 32'h0, 32'd12);

      // start + cancel + MTHI in the same idle cycle: write lands, start is dropped
      start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd5; cancel = 1'b1;
      hi_we = 1'b1; wdata = 32'hABCD;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0; hi_we = 1'b0;
      check("idle_cancel.busy", 64'(busy), 64'd0);
      check("idle_cancel.hi", 64'(hi), 64'hABCD);
      check("idle_cancel.lo", 64'(lo), 64'(mLo));
      mHi = 32'hABCD;
      @(negedge clk);
      check("idle_cancel.done", 64'(done), 64'd0);

      divOp("div_m7d2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
      divOp("div_minm1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
      divOp("div_7dm2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
      divOp("divu_100d7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
      divOp("divu_maxd1", OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'h0);
      divOp("divu_5d0", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5);
      divOp("div_m7d0", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9);

      runOp("mult_cancel10", OP_MULT, 32'd9, 32'd9, 1'b0, -1, 10, 10, 1'b0, mHi, mLo);
      runOp("mult_cancelfix", OP_MULT, 32'd9, 32'd9, 1'b0, -1, 33, 33, 1'b0, mHi, mLo);
      runOp("div_cancel5", OP_DIV, 32'd100, 32'd3, 1'b0, -1, 5, DIV_EN ? 5 : 1,
            DIV_EN ? 1'b0 : 1'b1, mHi, mLo);
      runOp("mult_refill", OP_MULT, 32'd1000, 32'hFFFFFFFF, 1'b0, -1, -1, 33, 1'b1,
            32'hFFFFFFFF, 32'hFFFFFC18);

      // asynchronous reset mid-operation
      start = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("rst_mid.busy_before", 64'(busy), 64'd1);
      rst = 1'b0;
      #1;
      check("rst_mid.busy", 64'(busy), 64'd0);
      check("rst_mid.done", 64'(done), 64'd0);
      check("rst_mid.hi", 64'(hi), 64'd0);
      check("rst_mid.lo", 64'(lo), 64'd0);
      mHi = '0; mLo = '0;
      @(negedge clk);
      rst = 1'b1;
      runOp("multu_after_rst", OP_MULTU, 32'd6, 32'd7, 1'b0, -1, -1, 33, 1'b1, 32'h0, 32'd42);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
